// File: rtl/demorgan_selftest_seq.sv
// demorgan_selftest_seq
// Self-test sequencer for the gate-level De Morgan datapath. After a start
// request it walks every {A,B} vector, holds each one for a settle interval,
// then samples both sides of both laws. Each side is checked against the
// other and against the golden value. Failing samples are counted in a
// saturating counter and recorded in a per-vector fail map. A one-cycle
// done pulse ends the run, and pass reports a clean run.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   start                run request, only honoured in IDLE
//   busy, done, pass     run status (done is a one-cycle pulse)
//   drive_a, drive_b     stimulus to the datapath
//   obs_law1_lhs/rhs     ~(A&B) and ~A|~B observed from the datapath
//   obs_law2_lhs/rhs     ~(A|B) and ~A&~B observed from the datapath
//   mismatch_cnt         failing samples this run, saturating
//   fail_vec             bit i set if vector {A,B}=i failed in any pass
//
// Build option: DEMORGAN_SEQ_STOP_ON_FAIL_EN ends the run at the first
// failing sample instead of finishing the sweep.
//
// state  | meaning
// IDLE   | waiting for start, results and drive held
// SETTLE | vector driven, waiting SETTLE_CYCLES extra cycles
// SAMPLE | observe datapath, record result, pick next vector
// DONE   | one-cycle done pulse, pass valid

module demorgan_selftest_seq #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             drive_a,
    output logic             drive_b,
    input  logic             obs_law1_lhs,
    input  logic             obs_law1_rhs,
    input  logic             obs_law2_lhs,
    input  logic             obs_law2_rhs,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [3:0]       fail_vec
);

    localparam int settleW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int passW   = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [settleW-1:0] settleInit = settleW'(SETTLE_CYCLES);
    localparam logic [passW-1:0]   lastPass   = passW'(PASSES - 1);

`ifdef DEMORGAN_SEQ_STOP_ON_FAIL_EN
    localparam bit stopOnFail = 1'b1;
`else
    localparam bit stopOnFail = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } seqState;

    seqState            state, stateNext;
    logic [1:0]         vecIdx, vecIdxNext;
    logic [1:0]         vecInc;
    logic [passW-1:0]   passIdx, passIdxNext;
    logic [settleW-1:0] settleCnt, settleCntNext;
    logic               driveANext, driveBNext, passNext;
    logic [CNT_W-1:0]   mismatchNext;
    logic [3:0]         failVecNext;
    logic               sampleFail;

    assign vecInc = vecIdx + 2'd1;

    // Checked against the registered drive, which is what the datapath sees.
    assign sampleFail = (obs_law1_lhs != obs_law1_rhs)
                      | (obs_law2_lhs != obs_law2_rhs)
                      | (obs_law1_lhs != ~(drive_a & drive_b))
                      | (obs_law2_lhs != ~(drive_a | drive_b));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            vecIdx       <= '0;
            passIdx      <= '0;
            settleCnt    <= '0;
            drive_a      <= 1'b0;
            drive_b      <= 1'b0;
            mismatch_cnt <= '0;
            fail_vec     <= '0;
            pass         <= 1'b0;
        end else begin
            state        <= stateNext;
            vecIdx       <= vecIdxNext;
            passIdx      <= passIdxNext;
            settleCnt    <= settleCntNext;
            drive_a      <= driveANext;
            drive_b      <= driveBNext;
            mismatch_cnt <= mismatchNext;
            fail_vec     <= failVecNext;
            pass         <= passNext;
        end
    end

    always_comb begin
        stateNext     = state;
        vecIdxNext    = vecIdx;
        passIdxNext   = passIdx;
        settleCntNext = settleCnt;
        driveANext    = drive_a;
        driveBNext    = drive_b;
        mismatchNext  = mismatch_cnt;
        failVecNext   = fail_vec;
        passNext      = pass;

        case (state)
            IDLE: begin
                if (start) begin
                    stateNext     = SETTLE;
                    vecIdxNext    = 2'd0;
                    passIdxNext   = '0;
                    settleCntNext = settleInit;
                    driveANext    = 1'b0;
                    driveBNext    = 1'b0;
                    mismatchNext  = '0;
                    failVecNext   = '0;
                    passNext      = 1'b0;
                end
            end

            SETTLE: begin
                if (settleCnt != '0) begin
                    settleCntNext = settleCnt - settleW'(1);
                end else begin
                    stateNext = SAMPLE;
                end
            end

            SAMPLE: begin
                if (sampleFail) begin
                    if (mismatch_cnt != '1) begin
                        mismatchNext = mismatch_cnt + CNT_W'(1);
                    end
                    failVecNext[vecIdx] = 1'b1;
                end

                if (sampleFail && stopOnFail) begin
                    stateNext = DONE;
                    passNext  = 1'b0;
                end else if (vecIdx != 2'd3) begin
                    stateNext     = SETTLE;
                    vecIdxNext    = vecInc;
                    settleCntNext = settleInit;
                    driveANext    = vecInc[1];
                    driveBNext    = vecInc[0];
                end else if (passIdx != lastPass) begin
                    stateNext     = SETTLE;
                    vecIdxNext    = 2'd0;
                    passIdxNext   = passIdx + passW'(1);
                    settleCntNext = settleInit;
                    driveANext    = 1'b0;
                    driveBNext    = 1'b0;
                end else begin
                    stateNext = DONE;
                    // Include the final sample, which is not yet in fail_vec.
                    passNext  = (fail_vec == 4'b0000) && !sampleFail;
                end
            end

            DONE: begin
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_demorgan_selftest_seq.sv
module tb_demorgan_selftest_seq;

    logic       clk;
    logic       rst_n;
    logic [2:0] startV;
    logic [2:0] busyV, doneV, passV, daV, dbV;
    logic [3:0] fv0, fv1, fv2;
    logic [3:0] mis0, mis2;
    logic [2:0] mis1;
    // observation bits: [3]=law1_lhs [2]=law1_rhs [1]=law2_lhs [0]=law2_rhs
    logic [3:0] obs0, obs1, obs2;

    logic [3:0] flip [3][4];
    logic [3:0] fMask [3];
    logic [3:0] fVal [3];

    int vectors = 0;
    int miscompares = 0;

    int sCyc [3]   = '{2, 2, 0};
    int nPass [3]  = '{1, 3, 1};
    int cntMax [3] = '{15, 7, 15};

`ifdef DEMORGAN_SEQ_STOP_ON_FAIL_EN
    bit stopOnFail = 1'b1;
`else
    bit stopOnFail = 1'b0;
`endif

    demorgan_selftest_seq dut0 (
        .clk(clk), .rst_n(rst_n), .start(startV[0]),
        .busy(busyV[0]), .done(doneV[0]), .pass(passV[0]),
        .drive_a(daV[0]), .drive_b(dbV[0]),
        .obs_law1_lhs(obs0[3]), .obs_law1_rhs(obs0[2]),
        .obs_law2_lhs(obs0[1]), .obs_law2_rhs(obs0[0]),
        .mismatch_cnt(mis0), .fail_vec(fv0)
    );

    demorgan_selftest_seq #(.SETTLE_CYCLES(2), .PASSES(3), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(startV[1]),
        .busy(busyV[1]), .done(doneV[1]), .pass(passV[1]),
        .drive_a(daV[1]), .drive_b(dbV[1]),
        .obs_law1_lhs(obs1[3]), .obs_law1_rhs(obs1[2]),
        .obs_law2_lhs(obs1[1]), .obs_law2_rhs(obs1[0]),
        .mismatch_cnt(mis1), .fail_vec(fv1)
    );

    demorgan_selftest_seq #(.SETTLE_CYCLES(0), .PASSES(1), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(startV[2]),
        .busy(busyV[2]), .done(doneV[2]), .pass(passV[2]),
        .drive_a(daV[2]), .drive_b(dbV[2]),
        .obs_law1_lhs(obs2[3]), .obs_law1_rhs(obs2[2]),
        .obs_law2_lhs(obs2[1]), .obs_law2_rhs(obs2[0]),
        .mismatch_cnt(mis2), .fail_vec(fv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: correct gate outputs, optionally flipped per vector or
    // forced to a stuck value per observation bit.
    function automatic logic [3:0] obsFor(int d, int v);
        logic a, b, g1, g2;
        logic [3:0] gold;
        a = v[1];
        b = v[0];
        g1 = ~(a & b);
        g2 = ~(a | b);
        gold = {g1, g1, g2, g2};
        return ((gold ^ flip[d][v]) & ~fMask[d]) | (fVal[d] & fMask[d]);
    endfunction

    function automatic bit vecFails(int d, int v);
        logic [3:0] o;
        logic a, b;
        o = obsFor(d, v);
        a = v[1];
        b = v[0];
        return (o[3] != o[2]) || (o[1] != o[0]) ||
               (o[3] != ~(a & b)) || (o[1] != ~(a | b));
    endfunction

    always_comb begin
        obs0 = obsFor(0, int'({daV[0], dbV[0]}));
        obs1 = obsFor(1, int'({daV[1], dbV[1]}));
        obs2 = obsFor(2, int'({daV[2], dbV[2]}));
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic readOut(input int d, output logic bo, output logic dn,
                           output logic p, output logic [1:0] drv,
                           output logic [3:0] cnt, output logic [3:0] fvec);
        bo  = busyV[d];
        dn  = doneV[d];
        p   = passV[d];
        drv = {daV[d], dbV[d]};
        case (d)
            0:       begin cnt = mis0;          fvec = fv0; end
            1:       begin cnt = {1'b0, mis1};  fvec = fv1; end
            default: begin cnt = mis2;          fvec = fv2; end
        endcase
    endtask

    // One run on DUT d, started in the current (negedge-aligned) cycle, with
    // expectations built from a plain sweep over the vector list.
    task automatic runCheck(input int d, input string name);
        int seq[$];
        int cnt, per, nS, doneC, vIdx;
        logic [3:0] fvE;
        bit stopped, passE;
        logic bo, dn, p;
        logic [1:0] drv;
        logic [3:0] c4, f4;
        cnt = 0;
        fvE = 4'b0000;
        stopped = 1'b0;
        for (int pp = 0; pp < nPass[d] && !stopped; pp++) begin
            for (int v = 0; v < 4 && !stopped; v++) begin
                seq.push_back(v);
                if (vecFails(d, v)) begin
                    if (cnt < cntMax[d]) cnt++;
                    fvE[v] = 1'b1;
                    if (stopOnFail) stopped = 1'b1;
                end
            end
        end
        passE = (fvE == 4'b0000);
        per = sCyc[d] + 2;
        nS = seq.size();
        doneC = 1 + nS * per;

        startV[d] = 1'b1;
        for (int c = 1; c <= doneC + 1; c++) begin
            @(posedge clk);
            @(negedge clk);
            startV[d] = 1'b0;
            readOut(d, bo, dn, p, drv, c4, f4);
            vIdx = (c - 1) / per;
            if (vIdx > nS - 1) vIdx = nS - 1;
            check({name, "_drive"}, drv, seq[vIdx]);
            check({name, "_busy"}, bo, (c <= doneC));
            check({name, "_done"}, dn, (c == doneC));
            if (c == 1) begin
                check({name, "_clr_cnt"}, c4, 0);
                check({name, "_clr_fv"}, f4, 0);
                check({name, "_clr_pass"}, p, 0);
            end
            if (c >= doneC) begin
                check({name, "_pass"}, p, passE);
                check({name, "_cnt"}, c4, cnt);
                check({name, "_fv"}, f4, fvE);
            end
        end
    endtask

    initial begin
        int runStart, vIdx, d;
        bit inRun;
        logic bo, dn, p;
        logic [1:0] drv;
        logic [3:0] c4, f4;

        rst_n = 1'b0;
        startV = 3'b000;
        for (int i = 0; i < 3; i++) begin
            fMask[i] = 4'h0;
            fVal[i] = 4'h0;
            for (int v = 0; v < 4; v++) flip[i][v] = 4'h0;
        end
        repeat (2) @(negedge clk);

        check("rst_busy", busyV, 0);
        check("rst_done", doneV, 0);
        check("rst_pass", passV, 0);
        check("rst_drive", {daV, dbV}, 0);
        check("rst_cnt", {mis0, mis1, mis2}, 0);
        check("rst_fv", {fv0, fv1, fv2}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // clean datapath, defaults
        runCheck(0, "t1");

        // law1 rhs stuck at 0
        fMask[0] = 4'b0100;
        fVal[0] = 4'b0000;
        runCheck(0, "t2");
        fMask[0] = 4'b0000;

        // three passes, law2 lhs stuck at 1, 3-bit counter saturates
        fMask[1] = 4'b0010;
        fVal[1] = 4'b0010;
        runCheck(1, "t3");
        fMask[1] = 4'b0000;
        fVal[1] = 4'b0000;

        // zero settle, ignored start while busy, back-to-back runs
        flip[2][3] = 4'b0001;
        startV[2] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            readOut(2, bo, dn, p, drv, c4, f4);
            runStart = (c >= 31) ? 30 : (c >= 21) ? 20 : 0;
            inRun = (c > runStart) && (c <= runStart + 9);
            vIdx = (c - runStart - 1) / 2;
            if (!inRun || vIdx > 3) vIdx = 3;
            check("t4_busy", bo, inRun);
            check("t4_done", dn, inRun && (c == runStart + 9));
            check("t4_drive", drv, vIdx);
            if (c == 9) begin
                check("t4_pass1", p, 0);
                check("t4_cnt1", c4, 1);
                check("t4_fv1", f4, 4'b1000);
            end
            if (c == 21) begin
                check("t4_clr_cnt", c4, 0);
                check("t4_clr_fv", f4, 0);
                check("t4_clr_pass", p, 0);
            end
            if (c == 29 || c == 30) begin
                check("t4_pass2", p, 1);
                check("t4_cnt2", c4, 0);
                check("t4_fv2", f4, 0);
            end
            if (c == 12) flip[2][3] = 4'b0000;
            startV[2] = (c == 5) || (c >= 20 && c <= 30);
        end

        // reset in the middle of a run
        if (!stopOnFail) flip[0][0] = 4'b1000;
        startV[0] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            startV[0] = 1'b0;
            readOut(0, bo, dn, p, drv, c4, f4);
            check("t5_busy", bo, 1);
            if (c == 6) check("t5_cnt_pre", c4, stopOnFail ? 0 : 1);
        end
        rst_n = 1'b0;
        #1;
        readOut(0, bo, dn, p, drv, c4, f4);
        check("t5_rst_busy", bo, 0);
        check("t5_rst_done", dn, 0);
        check("t5_rst_drive", drv, 0);
        check("t5_rst_cnt", c4, 0);
        check("t5_rst_fv", f4, 0);
        repeat (3) begin
            @(negedge clk);
            check("t5_hold_done", doneV[0], 0);
            check("t5_hold_busy", busyV[0], 0);
        end
        rst_n = 1'b1;
        flip[0][0] = 4'b0000;
        @(negedge clk);
        runCheck(0, "t5b");

        // single fault at vector 01
        flip[0][1] = 4'b0100;
        runCheck(0, "t6");
        flip[0][1] = 4'b0000;

        // random per-vector fault patterns on all three configurations
        for (int r = 0; r < 8; r++) begin
            d = $urandom_range(0, 2);
            for (int v = 0; v < 4; v++) begin
                if ($urandom_range(0, 2) == 0)
                    flip[d][v] = 4'($urandom_range(1, 15));
                else
                    flip[d][v] = 4'h0;
            end
            runCheck(d, "rand");
            for (int v = 0; v < 4; v++) flip[d][v] = 4'h0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
